regfile_sb: RTL and testbench

- Receiving end of the writeback write port: 32 x 32-bit general register file with a per-register pending-write scoreboard.
- Writeback drives reg_add/reg_data/reg_wr on the falling edge. This block samples them on the rising edge.
- Decode side presents source and destination registers at issue. The block returns registered operands with writeback bypass, and flags a hazard when an operand or destination is still pending.

---
 rtl/regfile_sb.sv | 181 ++++++++++++++++++
 tb/tb_regfile_sb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Purpose:
//   Receiving end of the writeback write port. Holds a 32 x DATA_W general
//   register file and a per-register count of writes that have been issued
//   but not yet written back. Decode presents source and destination
//   registers at issue. The block returns registered operands with
//   write-first bypass from the writeback port. It also raises a
//   combinational hazard while an operand is still pending, or while the
//   destination's pending count would overflow.
//
// Ports:
//   clock        in   system clock; all state updates on posedge
//   reset        in   asynchronous, active-high
//   reg_add      in   [4:0]        writeback destination register
//   reg_data     in   [DATA_W-1:0] writeback data
//   reg_wr       in   writeback write enable
//   issue_valid  in   decode presents an instruction this cycle
//   issue_rs     in   [4:0]        source register A
//   issue_rt     in   [4:0]        source register B
//   issue_dest   in   [4:0]        destination register
//   issue_wr     in   instruction will write issue_dest
//   rs_data      out  [DATA_W-1:0] registered operand A (1-cycle latency)
//   rt_data      out  [DATA_W-1:0] registered operand B (1-cycle latency)
//   hazard       out  combinational stall request for the current issue
//   sb_err       out  sticky: writeback hit a register with no pending write
//
// Issue handshake:
//   issue_valid acts as "valid" and !hazard acts as "ready". An instruction
//   is accepted on a rising edge when issue_valid && !hazard. Decode must
//   hold the same instruction stable until it is accepted. hazard depends
//   only on the current inputs and the pre-edge state, so it is valid in
//   the same cycle. Writeback has no back-pressure: reg_wr is taken on
//   every rising edge.
// -----------------------------------------------------------------------------
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [4:0]        reg_add,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              reg_wr,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rs,
   input  logic [4:0]        issue_rt,
   input  logic [4:0]        issue_dest,
   input  logic              issue_wr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              hazard,
   output logic              sb_err
);

   localparam int               NREG    = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Storage. Entry 0 is reset to zero and is never written, so it always
   // reads back as zero.
   logic [DATA_W-1:0]           regs [NREG];
   logic [NREG-1:0][CNT_W-1:0]  cnt;

   // Per-issue-port lookups.
   logic [CNT_W-1:0]  cnt_rs, cnt_rt, cnt_dest;
   logic              ret_rs, ret_rt, ret_dest;
   logic              busy_rs, busy_rt, full_dest;
   logic              accept;
   logic [DATA_W-1:0] rd_rs, rd_rt;
   logic              wb_live;

   // A writeback to register 0 is discarded entirely. It never writes,
   // never retires a pending write, and never flags an error.
   assign wb_live = reg_wr && (reg_add != 5'd0);

   // ---------------------------------------------------------------------
   // Hazard and operand selection
   // ---------------------------------------------------------------------
   always_comb begin
      cnt_rs    = cnt[issue_rs];
      cnt_rt    = cnt[issue_rt];
      cnt_dest  = cnt[issue_dest];

      ret_rs    = wb_live && (reg_add == issue_rs);
      ret_rt    = wb_live && (reg_add == issue_rt);
      ret_dest  = wb_live && (reg_add == issue_dest);

      // Effective count = count minus a writeback landing this cycle,
      // floored at zero. "Non-zero" is equivalent to: count is non-zero
      // and this is not the last outstanding write retiring right now.
      busy_rs   = (cnt_rs != '0) && !((cnt_rs == CNT_ONE) && ret_rs);
      busy_rt   = (cnt_rt != '0) && !((cnt_rt == CNT_ONE) && ret_rt);

      // The destination is full only if it is saturated and nothing
      // retires this cycle. A concurrent retire frees one slot for the
      // new write.
      full_dest = (cnt_dest == CNT_MAX) && !ret_dest;

      hazard    = issue_valid && (busy_rs || busy_rt || (issue_wr && full_dest));
      accept    = issue_valid && !hazard;

      // Write-first bypass. Register 0 yields zero because its storage is
      // zero and ret_* can never be true for it.
      rd_rs     = ret_rs ? reg_data : regs[issue_rs];
      rd_rt     = ret_rt ? reg_data : regs[issue_rt];
   end

   // ---------------------------------------------------------------------
   // Register file write port
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_live) begin
         regs[reg_add] <= reg_data;
      end
   end

   // ---------------------------------------------------------------------
   // Registered operands: updated only when the issue is accepted
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rs_data <= '0;
         rt_data <= '0;
      end else if (accept) begin
         rs_data <= rd_rs;
         rt_data <= rd_rt;
      end
   end

   // ---------------------------------------------------------------------
   // Sticky error: a writeback arrived for a register with nothing pending
   // ---------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sb_err <= 1'b0;
      end else if (wb_live && (cnt[reg_add] == '0)) begin
         sb_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Pending-write counters, one per register 1..31
   // ---------------------------------------------------------------------
   assign cnt[0] = '0;

   for (genvar g = 1; g < NREG; g++) begin : g_cnt
      localparam logic [4:0] IDX = 5'(g);

      logic             ret;
      logic             inc;
      logic             dec;
      logic [CNT_W-1:0] cnt_q;

      assign ret = reg_wr && (reg_add == IDX);
      assign inc = accept && issue_wr && (issue_dest == IDX);
      // A retire with nothing pending is an error and leaves the count
      // at zero instead of wrapping.
      assign dec = ret && (cnt_q != '0);

      // inc cannot overflow: hazard blocks the issue when the count is
      // saturated and no retire is landing in the same cycle.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
         end else if (inc && !dec) begin
            cnt_q <= cnt_q + CNT_ONE;
         end else if (dec && !inc) begin
            cnt_q <= cnt_q - CNT_ONE;
         end
      end

      assign cnt[g] = cnt_q;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Bench for regfile_sb. Each scenario task builds a table of cycles. A row
// holds one writeback, one issue and the expected outcome. The expected
// operand pair is pushed into exp_q when the row is driven. It is popped and
// compared once the registered outputs settle after the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  reg_add = '0;
   logic [31:0] reg_data = '0;
   logic        reg_wr = 1'b0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rs = '0;
   logic [4:0]  issue_rt = '0;
   logic [4:0]  issue_dest = '0;
   logic        issue_wr = 1'b0;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hazard;
   logic        sb_err;

   regfile_sb #(.DATA_W(32), .CNT_W(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .reg_add     (reg_add),
      .reg_data    (reg_data),
      .reg_wr      (reg_wr),
      .issue_valid (issue_valid),
      .issue_rs    (issue_rs),
      .issue_rt    (issue_rt),
      .issue_dest  (issue_dest),
      .issue_wr    (issue_wr),
      .rs_data     (rs_data),
      .rt_data     (rt_data),
      .hazard      (hazard),
      .sb_err      (sb_err)
   );

   // ---------------------------------------------------------------------
   // Clock / watchdog
   // ---------------------------------------------------------------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Scoreboard state and counters
   // ---------------------------------------------------------------------
   logic [63:0] exp_q [$];
   int          vectors = 0;
   int          errors  = 0;

   logic        obs_hazard;
   logic [31:0] obs_rs, obs_rt;
   logic        obs_err;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        ww;
      logic        iv;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic        iw;
      logic        eh;
      logic [31:0] ers;
      logic [31:0] ert;
      logic        eerr;
   } row_t;

   function automatic row_t mk(input logic [4:0] wa, input logic [31:0] wd, input logic ww,
                               input logic iv, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dest, input logic iw, input logic eh,
                               input logic [31:0] ers, input logic [31:0] ert, input logic eerr);
      row_t r;
      r.wa = wa; r.wd = wd; r.ww = ww;
      r.iv = iv; r.rs = rs; r.rt = rt; r.dest = dest; r.iw = iw;
      r.eh = eh; r.ers = ers; r.ert = ert; r.eerr = eerr;
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Driver: apply one row at the falling edge. Capture the combinational
   // hazard before the rising edge and the registered outputs just after it.
   // ---------------------------------------------------------------------
   task automatic drive(input row_t r);
      @(negedge clock);
      reg_add     = r.wa;
      reg_data    = r.wd;
      reg_wr      = r.ww;
      issue_valid = r.iv;
      issue_rs    = r.rs;
      issue_rt    = r.rt;
      issue_dest  = r.dest;
      issue_wr    = r.iw;
      #1;
      obs_hazard = hazard;
      @(posedge clock);
      #1;
      obs_rs  = rs_data;
      obs_rt  = rt_data;
      obs_err = sb_err;
      reg_wr      = 1'b0;
      issue_valid = 1'b0;
      issue_wr    = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------
   task automatic test_reset();
      row_t rows [$];
      logic [63:0] exp;
      reset = 1'b1;
      @(posedge clock);
      #1;
      vectors++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset rs_data: got %h expected %h", rs_data, 32'h0); end
      vectors++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset rt_data: got %h expected %h", rt_data, 32'h0); end
      vectors++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset sb_err: got %b expected 0", sb_err); end
      vectors++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset hazard: got %b expected 0", hazard); end
      @(negedge clock);
      reset = 1'b0;
      rows.push_back(mk(5'd0, 32'h0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL reset_issue[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL reset_issue[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL reset_issue[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
   endtask

   task automatic test_write_read();
      row_t rows [$];
      logic [63:0] exp;
      // Issue a write to 3 first so the writeback is legitimate.
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0));
      rows.push_back(mk(5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
      // Writes to register 0 are dropped, including with a concurrent read.
      rows.push_back(mk(5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
      rows.push_back(mk(5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL write_read[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL write_read[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL write_read[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
   endtask

   task automatic test_bypass();
      row_t rows [$];
      logic [63:0] exp;
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
      // Pending source stalls; operands hold.
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0));
      // Retire lands in the same cycle: no stall, value bypassed.
      rows.push_back(mk(5'd4, 32'h12345678, 1'b1, 1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0, 32'h12345678, 32'hDEADBEEF, 1'b0));
      rows.push_back(mk(5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678, 1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL bypass[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL bypass[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL bypass[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
   endtask

   task automatic test_overflow();
      row_t rows [$];
      logic [63:0] exp;
      for (int k = 0; k < 3; k++) begin
         rows.push_back(mk(5'd0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0));
      end
      // Count saturated at 3: a fourth write to 9 stalls.
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0,  32'h0,        1'b0));
      // A concurrent retire frees a slot: accepted, count stays 3.
      rows.push_back(mk(5'd9, 32'hA1, 1'b1, 1'b1, 5'd0, 5'd4, 5'd9, 1'b1, 1'b0, 32'h0,  32'h12345678, 1'b0));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0,  32'h12345678, 1'b0));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1, 32'h0,  32'h12345678, 1'b0));
      // Drain: 3 -> 2 -> 1 -> 0. The last retire plus read bypasses.
      rows.push_back(mk(5'd9, 32'hA2, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,  32'h12345678, 1'b0));
      rows.push_back(mk(5'd9, 32'hA3, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0,  32'h12345678, 1'b0));
      rows.push_back(mk(5'd9, 32'hA4, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 32'hA4, 32'hA4,       1'b0));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd9, 5'd9, 1'b1, 1'b0, 32'h0,  32'hA4,       1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL overflow[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL overflow[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL overflow[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
   endtask

   task automatic test_sb_err();
      row_t rows [$];
      logic [63:0] exp;
      // Drain the single write to 9 left pending by the previous scenario.
      rows.push_back(mk(5'd9, 32'hB9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,  32'hA4, 1'b0));
      rows.push_back(mk(5'd6, 32'h66, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,  32'hA4, 1'b1));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd6, 5'd9, 5'd0, 1'b0, 1'b0, 32'h66, 32'hB9, 1'b1));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h66, 32'hB9, 1'b1));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL sb_err[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL sb_err[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL sb_err[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      vectors++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sb_err_reset: got %b expected 0", sb_err); end
      vectors++; if (rs_data !== 32'h0) begin errors++; $display("FAIL sb_err_reset rs_data: got %h expected 0", rs_data); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_async_reset();
      row_t rows [$];
      logic [63:0] exp;
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0));
      rows.push_back(mk(5'd5, 32'h55, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd5, 5'd0, 5'd2, 1'b1, 1'b0, 32'h55, 32'h0,  1'b0));
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 32'h55, 32'h55, 1'b0));
      // cnt(2) = 2: a read of 2 must stall before the reset.
      rows.push_back(mk(5'd0, 32'h0,  1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 32'h55, 32'h55, 1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL async_pre[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL async_pre[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL async_pre[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
      // Assert reset between edges; outputs must clear without a clock.
      #2;
      reset = 1'b1;
      #1;
      vectors++; if (rs_data !== 32'h0) begin errors++; $display("FAIL async rs_data: got %h expected 0", rs_data); end
      vectors++; if (rt_data !== 32'h0) begin errors++; $display("FAIL async rt_data: got %h expected 0", rt_data); end
      issue_valid = 1'b1;
      issue_rs    = 5'd2;
      issue_rt    = 5'd0;
      #1;
      vectors++; if (hazard !== 1'b0) begin errors++; $display("FAIL async hazard_in_reset: got %b expected 0", hazard); end
      issue_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      rows.delete();
      rows.push_back(mk(5'd0, 32'h0, 1'b0, 1'b1, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
      foreach (rows[i]) begin
         exp_q.push_back({rows[i].ers, rows[i].ert});
         drive(rows[i]);
         vectors++; if (obs_hazard !== rows[i].eh) begin errors++; $display("FAIL async_post[%0d] hazard: got %b expected %b", i, obs_hazard, rows[i].eh); end
         exp = exp_q.pop_front();
         vectors++; if ({obs_rs, obs_rt} !== exp) begin errors++; $display("FAIL async_post[%0d] operands: got %h/%h expected %h/%h", i, obs_rs, obs_rt, exp[63:32], exp[31:0]); end
         vectors++; if (obs_err !== rows[i].eerr) begin errors++; $display("FAIL async_post[%0d] sb_err: got %b expected %b", i, obs_err, rows[i].eerr); end
      end
   endtask

   // ---------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------
   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_overflow();
      test_sb_err();
      test_async_reset();
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
